// File: rtl/pipe_pkg.sv
// Pipeline-wide constants: control-bundle bit map shared by decode, forwarding and EX,
// plus the ID/EX update-action encoding.
package pipe_pkg;
    localparam int CTRL_W           = 12;
    localparam int CTRL_REGWRITE    = 0;
    localparam int CTRL_MEMREAD     = 1;
    localparam int CTRL_MEMWRITE    = 2;
    localparam int CTRL_MEMTOREG_LO = 3;
    localparam int CTRL_MEMTOREG_HI = 4;
    localparam int CTRL_ALUSRC      = 5;
    localparam int CTRL_ALUOP_LO    = 6;
    localparam int CTRL_ALUOP_HI    = 9;
    localparam int CTRL_BRANCH      = 10;
    localparam int CTRL_JUMP        = 11;

    typedef logic [CTRL_W-1:0] ctrl_t;

    typedef enum logic [1:0] {
        UPD_HOLD,
        UPD_FLUSH,
        UPD_LOADUSE,
        UPD_LOAD
    } upd_e;

    function automatic logic is_load(input ctrl_t c);
        return c[CTRL_MEMREAD];
    endfunction
endpackage

// File: rtl/idex_hazard_reg_if.sv
// Decode-side inputs, EX-side register outputs and stall/flush controls of the ID/EX stage.
interface idex_hazard_reg_if #(
    parameter int XLEN = 32
);
    import pipe_pkg::*;

    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rd1;
    logic [XLEN-1:0] id_rd2;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            id_use_rs1;
    logic            id_use_rs2;
    ctrl_t           id_ctrl;
    logic            ex_flush;
    logic            mem_stall;

    logic            IDEX_valid;
    logic [XLEN-1:0] IDEX_pc;
    logic [XLEN-1:0] IDEX_rd1;
    logic [XLEN-1:0] IDEX_rd2;
    logic [XLEN-1:0] IDEX_imm;
    logic [4:0]      IDEX_rs1;
    logic [4:0]      IDEX_rs2;
    logic [4:0]      IDEX_rd;
    ctrl_t           IDEX_ctrl;
    logic            stall_pc;
    logic            stall_ifid;
    logic            flush_ifid;

    modport master (
        output id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
               id_use_rs1, id_use_rs2, id_ctrl, ex_flush, mem_stall,
        input  IDEX_valid, IDEX_pc, IDEX_rd1, IDEX_rd2, IDEX_imm, IDEX_rs1, IDEX_rs2,
               IDEX_rd, IDEX_ctrl, stall_pc, stall_ifid, flush_ifid
    );

    modport slave (
        input  id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
               id_use_rs1, id_use_rs2, id_ctrl, ex_flush, mem_stall,
        output IDEX_valid, IDEX_pc, IDEX_rd1, IDEX_rd2, IDEX_imm, IDEX_rs1, IDEX_rs2,
               IDEX_rd, IDEX_ctrl, stall_pc, stall_ifid, flush_ifid
    );
endinterface

// File: rtl/hazard_detect.sv
// Purely combinational load-use comparator: a load in EX whose rd is read by the ID instruction.
module hazard_detect (
    input  logic            idex_valid,
    input  logic            idex_memread,
    input  logic [4:0]      idex_rd,
    input  logic            id_valid,
    input  logic [1:0]      src_use,
    input  logic [1:0][4:0] src_rs,
    output logic            load_use
);
    logic [1:0] src_hit;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_src
        assign src_hit[gi] = src_use[gi] & (idex_rd == src_rs[gi]);
    end

    // x0 is never a real producer, so a load targeting it cannot create a dependency.
    assign load_use = idex_valid & idex_memread & (idex_rd != 5'd0) & id_valid & (|src_hit);
endmodule

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, EX-redirect squash, memory-stall
// freeze and saturating bubble/flush performance counters.
module idex_hazard_reg
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    idex_hazard_reg_if.slave bus,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int PW = 4 * XLEN + 15 + CTRL_W;

    logic             valid_reg, valid_next;
    logic [PW-1:0]    payload_reg, payload_next;
    logic [PW-1:0]    id_payload;
    logic [CNT_W-1:0] bubble_cnt_reg, bubble_cnt_next;
    logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
    logic             load_use;
    logic             stall;
    upd_e             upd;

    assign id_payload = {bus.id_pc, bus.id_rd1, bus.id_rd2, bus.id_imm,
                         bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_ctrl};

    assign bus.IDEX_valid = valid_reg;
    assign {bus.IDEX_pc, bus.IDEX_rd1, bus.IDEX_rd2, bus.IDEX_imm,
            bus.IDEX_rs1, bus.IDEX_rs2, bus.IDEX_rd, bus.IDEX_ctrl} = payload_reg;

    hazard_detect u_hazard_detect (
        .idex_valid   (valid_reg),
        .idex_memread (is_load(bus.IDEX_ctrl)),
        .idex_rd      (bus.IDEX_rd),
        .id_valid     (bus.id_valid),
        .src_use      ({bus.id_use_rs2, bus.id_use_rs1}),
        .src_rs       ({bus.id_rs2, bus.id_rs1}),
        .load_use     (load_use)
    );

    // A redirect makes the ID instruction wrong-path, so it must not be held by a load-use stall.
    assign stall          = bus.mem_stall | (load_use & ~bus.ex_flush);
    assign bus.stall_pc   = stall;
    assign bus.stall_ifid = stall;
    assign bus.flush_ifid = bus.ex_flush & ~bus.mem_stall;

    always_comb begin
        upd = UPD_LOAD;
        if (bus.mem_stall) begin
            upd = UPD_HOLD;
        end else if (bus.ex_flush) begin
            upd = UPD_FLUSH;
        end else if (load_use) begin
            upd = UPD_LOADUSE;
        end
    end

    always_comb begin
        valid_next      = valid_reg;
        payload_next    = payload_reg;
        bubble_cnt_next = bubble_cnt_reg;
        flush_cnt_next  = flush_cnt_reg;
        case (upd)
            UPD_HOLD: ;
            UPD_FLUSH: begin
                valid_next   = 1'b0;
                payload_next = '0;
                if (!(&flush_cnt_reg)) begin
                    flush_cnt_next = flush_cnt_reg + CNT_W'(1);
                end
            end
            UPD_LOADUSE: begin
                valid_next   = 1'b0;
                payload_next = '0;
                if (!(&bubble_cnt_reg)) begin
                    bubble_cnt_next = bubble_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                // An empty ID slot becomes an uncounted bubble with all fields zeroed.
                valid_next   = bus.id_valid;
                payload_next = bus.id_valid ? id_payload : '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg      <= 1'b0;
            payload_reg    <= '0;
            bubble_cnt_reg <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            valid_reg      <= valid_next;
            payload_reg    <= payload_next;
            bubble_cnt_reg <= bubble_cnt_next;
            flush_cnt_reg  <= flush_cnt_next;
        end
    end

    assign bubble_cnt = bubble_cnt_reg;
    assign flush_cnt  = flush_cnt_reg;
endmodule

// File: tb/tb_idex_hazard_reg.sv
// Directed bench for idex_hazard_reg: expected ID/EX contents are queued when stimulus is
// driven and compared one cycle later; stall/flush outputs are checked in the same cycle.
module tb_idex_hazard_reg;
    import pipe_pkg::*;

    localparam int CW = 4;
    localparam logic [11:0] C_LW  = 12'h00B;
    localparam logic [11:0] C_ADD = 12'h001;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] ctrl;
        logic [3:0]  bub;
        logic [3:0]  fl;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] bubble_cnt;
    logic [CW-1:0] flush_cnt;

    exp_t q[$];
    exp_t cur;
    int   eb = 0;
    int   ef = 0;
    int   checks = 0;
    int   passed = 0;
    int   failed = 0;

    idex_hazard_reg_if #(.XLEN(32)) bus ();

    idex_hazard_reg #(.XLEN(32), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                          input logic u2, input logic [11:0] ctrl);
        bus.id_valid   = v;
        bus.id_pc      = pc;
        bus.id_rd1     = pc ^ 32'h5A5A_0000;
        bus.id_rd2     = pc + 32'd3;
        bus.id_imm     = pc << 1;
        bus.id_rs1     = rs1;
        bus.id_rs2     = rs2;
        bus.id_rd      = rd;
        bus.id_use_rs1 = u1;
        bus.id_use_rs2 = u2;
        bus.id_ctrl    = ctrl;
    endtask

    task automatic push_load();
        exp_t e;
        e.valid = 1'b1;
        e.pc    = bus.id_pc;
        e.rd1   = bus.id_pc ^ 32'h5A5A_0000;
        e.rd2   = bus.id_pc + 32'd3;
        e.imm   = bus.id_pc << 1;
        e.rs1   = bus.id_rs1;
        e.rs2   = bus.id_rs2;
        e.rd    = bus.id_rd;
        e.ctrl  = bus.id_ctrl;
        e.bub   = 4'(eb);
        e.fl    = 4'(ef);
        q.push_back(e);
    endtask

    task automatic push_bubble();
        exp_t e;
        e     = '0;
        e.bub = 4'(eb);
        e.fl  = 4'(ef);
        q.push_back(e);
    endtask

    task automatic push_hold();
        q.push_back(cur);
    endtask

    task automatic comb(input string tag, input logic sp, input logic fi);
        #1;
        chk({tag, ".stall_pc"}, 32'(bus.stall_pc), 32'(sp));
        chk({tag, ".stall_ifid"}, 32'(bus.stall_ifid), 32'(sp));
        chk({tag, ".flush_ifid"}, 32'(bus.flush_ifid), 32'(fi));
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            checks++;
            failed++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e   = q.pop_front();
            cur = e;
            chk({tag, ".valid"}, 32'(bus.IDEX_valid), 32'(e.valid));
            chk({tag, ".pc"},    bus.IDEX_pc,          e.pc);
            chk({tag, ".rd1"},   bus.IDEX_rd1,         e.rd1);
            chk({tag, ".rd2"},   bus.IDEX_rd2,         e.rd2);
            chk({tag, ".imm"},   bus.IDEX_imm,         e.imm);
            chk({tag, ".rs1"},   32'(bus.IDEX_rs1),    32'(e.rs1));
            chk({tag, ".rs2"},   32'(bus.IDEX_rs2),    32'(e.rs2));
            chk({tag, ".rd"},    32'(bus.IDEX_rd),     32'(e.rd));
            chk({tag, ".ctrl"},  32'(bus.IDEX_ctrl),   32'(e.ctrl));
            chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(e.bub));
            chk({tag, ".flush_cnt"},  32'(flush_cnt),  32'(e.fl));
            $display("step %-22s valid=%0d pc=%h rd=%0d ctrl=%h bub=%0d fl=%0d",
                     tag, bus.IDEX_valid, bus.IDEX_pc, bus.IDEX_rd, bus.IDEX_ctrl,
                     bubble_cnt, flush_cnt);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        eb  = 0;
        ef  = 0;
        push_bubble();
        tick(tag);
        rst = 1'b0;
    endtask

    initial begin
        cur           = '0;
        bus.ex_flush  = 1'b0;
        bus.mem_stall = 1'b0;
        set_id(1'b1, 32'hDEAD_0000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, C_LW);
        do_reset("reset");

        // Load-use on rs1: one bubble, then the held add enters EX.
        set_id(1'b1, 32'h100, 5'd2, 5'd3, 5'd5, 1'b1, 1'b1, C_LW);
        comb("lw_enter", 1'b0, 1'b0);
        push_load(); tick("lw_load");
        set_id(1'b1, 32'h104, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, C_ADD);
        comb("lu_rs1", 1'b1, 1'b0);
        eb++; push_bubble(); tick("lu_bubble");
        comb("lu_release", 1'b0, 1'b0);
        push_load(); tick("add_after_bubble");

        // Load to x0 never stalls, even against a reader of x0.
        set_id(1'b1, 32'h200, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1, C_LW);
        comb("lw_rd0_enter", 1'b0, 1'b0);
        push_load(); tick("lw_rd0_load");
        set_id(1'b1, 32'h204, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, C_ADD);
        comb("rd0_nostall", 1'b0, 1'b0);
        push_load(); tick("rd0_add_load");

        // Matching rs1 that is not actually read does not stall.
        set_id(1'b1, 32'h208, 5'd4, 5'd4, 5'd5, 1'b1, 1'b0, C_LW);
        comb("lw5_enter", 1'b0, 1'b0);
        push_load(); tick("lw5_load");
        set_id(1'b1, 32'h20C, 5'd5, 5'd3, 5'd10, 1'b0, 1'b1, C_ADD);
        comb("nouse_nostall", 1'b0, 1'b0);
        push_load(); tick("nouse_add_load");

        // Load-use through rs2.
        set_id(1'b1, 32'h210, 5'd1, 5'd1, 5'd6, 1'b1, 1'b0, C_LW);
        comb("lw6_enter", 1'b0, 1'b0);
        push_load(); tick("lw6_load");
        set_id(1'b1, 32'h214, 5'd1, 5'd6, 5'd11, 1'b1, 1'b1, C_ADD);
        comb("lu_rs2", 1'b1, 1'b0);
        eb++; push_bubble(); tick("lu_rs2_bubble");
        comb("lu_rs2_release", 1'b0, 1'b0);
        push_load(); tick("rs2_add_load");

        // Empty ID slot yields an uncounted bubble.
        set_id(1'b0, 32'h300, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, C_ADD);
        comb("idle", 1'b0, 1'b0);
        push_bubble(); tick("idle_bubble");

        // Flush beats a simultaneous load-use.
        set_id(1'b1, 32'h400, 5'd1, 5'd1, 5'd5, 1'b1, 1'b0, C_LW);
        comb("lw_f_enter", 1'b0, 1'b0);
        push_load(); tick("lw_f_load");
        set_id(1'b1, 32'h404, 5'd5, 5'd5, 5'd12, 1'b1, 1'b1, C_ADD);
        bus.ex_flush = 1'b1;
        comb("flush_lu", 1'b0, 1'b1);
        ef++; push_bubble(); tick("flush_bubble");
        bus.ex_flush = 1'b0;

        // Memory stall freezes everything, ignoring a flush that arrives meanwhile.
        set_id(1'b1, 32'h500, 5'd1, 5'd1, 5'd5, 1'b1, 1'b0, C_LW);
        comb("lw_m_enter", 1'b0, 1'b0);
        push_load(); tick("lw_m_load");
        set_id(1'b1, 32'h504, 5'd5, 5'd2, 5'd13, 1'b1, 1'b1, C_ADD);
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ex_flush = (i == 1);
            comb("memstall", 1'b1, 1'b0);
            push_hold(); tick("memstall_hold");
        end
        bus.ex_flush  = 1'b0;
        bus.mem_stall = 1'b0;
        comb("memstall_release", 1'b1, 1'b0);
        eb++; push_bubble(); tick("memstall_bubble");
        comb("memstall_after", 1'b0, 1'b0);
        push_load(); tick("memstall_add_load");

        // Reset the cycle after a bubble clears registers and counters.
        do_reset("reset2");
        set_id(1'b1, 32'h600, 5'd1, 5'd1, 5'd5, 1'b1, 1'b0, C_LW);
        push_load(); tick("lw_r_load");
        set_id(1'b1, 32'h604, 5'd5, 5'd5, 5'd14, 1'b1, 1'b1, C_ADD);
        comb("lu_r", 1'b1, 1'b0);
        eb++; push_bubble(); tick("lu_r_bubble");
        do_reset("reset_after_bubble");

        // Counter saturation: 20 dependent pairs into a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            set_id(1'b1, 32'h1000 + 32'(i * 8), 5'd1, 5'd1, 5'd5, 1'b1, 1'b0, C_LW);
            push_load(); tick("sat_lw");
            set_id(1'b1, 32'h1004 + 32'(i * 8), 5'd5, 5'd8, 5'd15, 1'b1, 1'b1, C_ADD);
            if (eb < 15) eb++;
            push_bubble(); tick("sat_bubble");
            push_load(); tick("sat_add");
        end
        chk("bubble_cnt_saturated", 32'(bubble_cnt), 32'd15);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
